// File: rtl/sc_datamem_io_if.sv
// Core-side request/acknowledge bus for the memory stage.
// The core drives the request fields; the memory stage returns ack/rdata/err.
interface sc_datamem_io_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err
  );
endinterface

// File: rtl/sc_datamem_io.sv
// Memory stage: synchronous word RAM plus memory-mapped LED/HEX/SW/KEY/timer I/O,
// accessed through a req/ack handshake with a one-cycle response.
module sc_datamem_io #(
  parameter int unsigned AW    = 8,
  parameter int unsigned SW_W  = 10,
  parameter int unsigned KEY_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  sc_datamem_io_if.slave    bus,
  input  logic [SW_W-1:0]   sw,
  input  logic [KEY_W-1:0]  key,
  output logic [31:0]       led,
  output logic [23:0]       hex,
  output logic              irq
);

  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_HEX    = 8'h04;
  localparam logic [7:0] OFF_SW     = 8'h10;
  localparam logic [7:0] OFF_KEY    = 8'h14;
  localparam logic [7:0] OFF_COUNT  = 8'h20;
  localparam logic [7:0] OFF_CMP    = 8'h24;
  localparam logic [7:0] OFF_STATUS = 8'h28;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  state_e             state_q;
  logic               ack_q;
  logic               err_q;
  logic [31:0]        rdata_q;

  logic [31:0]        mem [DEPTH];

  logic [31:0]        led_q;
  logic [23:0]        hex_q;
  logic [31:0]        cnt_q;
  logic [31:0]        cmp_q;
  logic               irq_q;
  logic [SW_W-1:0]    sw_meta_q;
  logic [SW_W-1:0]    sw_sync_q;
  logic [KEY_W-1:0]   key_meta_q;
  logic [KEY_W-1:0]   key_sync_q;

  logic               accept_c;
  logic               misalign_c;
  logic               is_io_c;
  logic [AW-1:0]      ram_idx_c;
  logic [7:0]         io_off_c;
  logic               io_hit_c;
  logic               io_ro_c;
  logic [31:0]        io_rdata_c;
  logic               err_c;
  logic               wr_ok_c;
  logic               ram_we_c;
  logic               io_we_c;

  // Decode is done on the request fields at the accept edge, which is when they are latched.
  assign accept_c   = (state_q == ST_IDLE) && bus.req && !reset;
  assign misalign_c = (bus.addr[1:0] != 2'b00);
  assign is_io_c    = (bus.addr[31:8] == 24'hFFFFFF);
  assign ram_idx_c  = bus.addr[AW+1:2];
  assign io_off_c   = bus.addr[7:0];

  always_comb begin
    io_hit_c   = 1'b1;
    io_ro_c    = 1'b0;
    io_rdata_c = 32'd0;
    case (io_off_c)
      OFF_LED:    io_rdata_c = led_q;
      OFF_HEX:    io_rdata_c = {8'd0, hex_q};
      OFF_SW: begin
        io_rdata_c = 32'(sw_sync_q);
        io_ro_c    = 1'b1;
      end
      OFF_KEY: begin
        io_rdata_c = 32'(key_sync_q);
        io_ro_c    = 1'b1;
      end
      OFF_COUNT:  io_rdata_c = cnt_q;
      OFF_CMP:    io_rdata_c = cmp_q;
      OFF_STATUS: io_rdata_c = {31'd0, irq_q};
      default:    io_hit_c   = 1'b0;
    endcase
  end

  assign err_c    = misalign_c || (is_io_c && !io_hit_c);
  assign wr_ok_c  = accept_c && bus.we && !err_c;
  assign ram_we_c = wr_ok_c && !is_io_c;
  assign io_we_c  = wr_ok_c && is_io_c && !io_ro_c;

  // Word RAM storage; left unreset so it maps onto a RAM macro.
  always_ff @(posedge clock) begin
    if (ram_we_c) begin
      mem[ram_idx_c] <= bus.wdata;
    end
  end

  // Handshake FSM; the response register doubles as the RAM read-data register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            state_q <= ST_RESP;
            ack_q   <= 1'b1;
            err_q   <= err_c;
            if (err_c || bus.we) begin
              rdata_q <= 32'd0;
            end else if (is_io_c) begin
              rdata_q <= io_rdata_c;
            end else begin
              rdata_q <= mem[ram_idx_c];
            end
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
      endcase
    end
  end

  // Peripheral registers, input synchronisers and the free-running timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q      <= 32'd0;
      hex_q      <= 24'd0;
      cnt_q      <= 32'd0;
      cmp_q      <= 32'hFFFF_FFFF;
      irq_q      <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '0;
      key_sync_q <= '0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= key;
      key_sync_q <= key_meta_q;

      if (io_we_c && io_off_c == OFF_LED) begin
        led_q <= bus.wdata;
      end
      if (io_we_c && io_off_c == OFF_HEX) begin
        hex_q <= bus.wdata[23:0];
      end
      if (io_we_c && io_off_c == OFF_CMP) begin
        cmp_q <= bus.wdata;
      end

      if (io_we_c && io_off_c == OFF_COUNT) begin
        cnt_q <= bus.wdata;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end

      // A match on the same edge as a software clear keeps the flag set.
      if (cnt_q == cmp_q) begin
        irq_q <= 1'b1;
      end else if (io_we_c && io_off_c == OFF_STATUS && bus.wdata[0]) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign led       = led_q;
  assign hex       = hex_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_sc_datamem_io.sv
// Self-checking bench for sc_datamem_io: directed steps plus randomized RAM/LED/HEX
// traffic checked against an array-based reference model.
module tb_sc_datamem_io;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [31:0] led;
  logic [23:0] hex;
  logic        irq;

  sc_datamem_io_if bus ();

  sc_datamem_io #(.AW(8), .SW_W(10), .KEY_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .sw    (sw),
    .key   (key),
    .led   (led),
    .hex   (hex),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  // Number of rising edges seen so far; read on falling edges.
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  logic [31:0] mem_m   [256];
  bit          known_m [256];
  logic [31:0] led_m;
  logic [23:0] hex_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One full access: drive, see ack for exactly the cycle after accept, then see it drop.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int unsigned acc);
    @(negedge clock);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(negedge clock);
    acc = cyc;
    bus.req = 1'b0;
    check("ack_high", 32'(bus.ack), 32'd1);
    rd = bus.rdata;
    er = bus.err;
    @(negedge clock);
    check("ack_pulse", 32'(bus.ack), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int unsigned acc, tw;
    logic [31:0] exp_cnt;

    for (int i = 0; i < 256; i++) begin
      known_m[i] = 1'b0;
      mem_m[i]   = 32'd0;
    end
    reset = 1'b1; sw = '0; key = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clock);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_led", led, 32'd0);
    check("rst_hex", 32'(hex), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    // Step 1: plain RAM read after reset
    access(1'b0, 32'h0000_0004, 32'd0, rd, er, acc);
    check("t1_err", 32'(er), 32'd0);
    check("t1_led", led, 32'd0);
    check("t1_hex", 32'(hex), 32'd0);
    check("t1_irq", 32'(irq), 32'd0);

    // Step 2: write, read back, read through the AW=8 alias
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, acc);
    mem_m[4] = 32'hDEAD_BEEF; known_m[4] = 1'b1;
    check("t2_wr_rdata", rd, 32'd0);
    check("t2_wr_err", 32'(er), 32'd0);
    access(1'b0, 32'h0000_0010, 32'd0, rd, er, acc);
    check("t2_rd", rd, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0410, 32'd0, rd, er, acc);
    check("t2_alias", rd, 32'hDEAD_BEEF);
    check("t2_alias_err", 32'(er), 32'd0);

    // Step 3: misaligned write is rejected and leaves RAM alone
    access(1'b1, 32'h0000_0013, 32'h1234_5678, rd, er, acc);
    check("t3_err", 32'(er), 32'd1);
    check("t3_rdata", rd, 32'd0);
    access(1'b0, 32'h0000_0010, 32'd0, rd, er, acc);
    check("t3_keep", rd, 32'hDEAD_BEEF);

    // Step 4: HEX/LED writes, HEX upper byte masking, unmapped offset
    access(1'b1, 32'hFFFF_FF04, 32'hFF0A_BCDE, rd, er, acc);
    hex_m = 24'h0A_BCDE;
    check("t4_hex", 32'(hex), 32'(hex_m));
    access(1'b1, 32'hFFFF_FF00, 32'h0000_00A5, rd, er, acc);
    led_m = 32'h0000_00A5;
    check("t4_led", led, led_m);
    access(1'b0, 32'hFFFF_FF04, 32'd0, rd, er, acc);
    check("t4_hex_rd", rd, 32'h000A_BCDE);
    access(1'b0, 32'hFFFF_FF30, 32'd0, rd, er, acc);
    check("t4_unmapped_err", 32'(er), 32'd1);
    check("t4_unmapped_rdata", rd, 32'd0);

    // Step 5: synchronised switches/keys, read-only write dropped
    @(negedge clock);
    sw = 10'h2AA; key = 4'h5;
    repeat (2) @(posedge clock);
    access(1'b0, 32'hFFFF_FF10, 32'd0, rd, er, acc);
    check("t5_sw", rd, 32'h0000_02AA);
    access(1'b0, 32'hFFFF_FF14, 32'd0, rd, er, acc);
    check("t5_key", rd, 32'h0000_0005);
    access(1'b1, 32'hFFFF_FF10, 32'h0000_0155, rd, er, acc);
    check("t5_ro_err", 32'(er), 32'd0);
    check("t5_ro_rdata", rd, 32'd0);
    access(1'b0, 32'hFFFF_FF10, 32'd0, rd, er, acc);
    check("t5_sw_keep", rd, 32'h0000_02AA);

    // Randomized traffic over RAM (aliased, sometimes misaligned) and LED/HEX
    for (int n = 0; n < 60; n++) begin
      int unsigned op, idx, mis;
      logic        w;
      logic [31:0] a, d;
      op  = $urandom_range(0, 7);
      d   = 32'($urandom);
      w   = 1'($urandom_range(0, 1));
      if (op <= 4) begin
        idx = $urandom_range(16, 47);
        mis = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
        a   = (32'($urandom_range(0, 1023)) << 10) | (32'(idx) << 2) | 32'(mis);
        access(w, a, d, rd, er, acc);
        if (mis != 0) begin
          check("rnd_mis_err", 32'(er), 32'd1);
          check("rnd_mis_rdata", rd, 32'd0);
        end else if (w) begin
          mem_m[idx] = d; known_m[idx] = 1'b1;
          check("rnd_wr_err", 32'(er), 32'd0);
          check("rnd_wr_rdata", rd, 32'd0);
        end else begin
          check("rnd_rd_err", 32'(er), 32'd0);
          if (known_m[idx]) check("rnd_rd_data", rd, mem_m[idx]);
        end
      end else if (op == 5) begin
        access(1'b1, 32'hFFFF_FF00, d, rd, er, acc);
        led_m = d;
        check("rnd_led", led, led_m);
      end else if (op == 6) begin
        access(1'b1, 32'hFFFF_FF04, d, rd, er, acc);
        hex_m = d[23:0];
        check("rnd_hex", 32'(hex), 32'(hex_m));
      end else begin
        access(1'b0, 32'hFFFF_FF00, 32'd0, rd, er, acc);
        check("rnd_led_rd", rd, led_m);
      end
    end

    // Step 6: timer compare/irq, clear, wrap, then reset mid-access
    access(1'b1, 32'hFFFF_FF24, 32'd5, rd, er, acc);
    check("t6_irq_pre", 32'(irq), 32'd0);
    access(1'b1, 32'hFFFF_FF20, 32'd0, rd, er, tw);
    while (cyc < tw + 5) @(negedge clock);
    check("t6_irq_not_yet", 32'(irq), 32'd0);
    @(negedge clock);
    check("t6_irq_set", 32'(irq), 32'd1);
    access(1'b0, 32'hFFFF_FF28, 32'd0, rd, er, acc);
    check("t6_status_rd", rd, 32'd1);
    access(1'b1, 32'hFFFF_FF28, 32'd1, rd, er, acc);
    check("t6_irq_clr", 32'(irq), 32'd0);
    access(1'b1, 32'hFFFF_FF20, 32'hFFFF_FFFF, rd, er, tw);
    access(1'b0, 32'hFFFF_FF20, 32'd0, rd, er, acc);
    exp_cnt = 32'hFFFF_FFFF + 32'(acc - tw - 1);
    check("t6_wrap_cnt", rd, exp_cnt);
    while (cyc < tw + 9) @(negedge clock);
    check("t6_irq_after_wrap", 32'(irq), 32'd1);

    access(1'b1, 32'hFFFF_FF00, 32'h0000_0055, rd, er, acc);
    check("t6_led_pre", led, 32'h0000_0055);
    @(negedge clock);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0000_0010; bus.wdata = 32'h1111_1111;
    reset = 1'b1;
    @(negedge clock);
    bus.req = 1'b0;
    reset = 1'b0;
    check("t6_rst_ack", 32'(bus.ack), 32'd0);
    check("t6_rst_led", led, 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_hex", 32'(hex), 32'd0);
    access(1'b0, 32'h0000_0010, 32'd0, rd, er, acc);
    check("t6_rst_nowrite", rd, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
